round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/noc_arb_pkg.sv | 19 +
 rtl/round_robin_arbiter_if.sv | 29 ++
 rtl/arb_pick.sv | 42 ++++
 rtl/round_robin_arbiter.sv | 87 ++++++++
 tb/tb_round_robin_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/noc_arb_pkg.sv
// Shared arbitration constants and helpers for NoC output-channel arbiters.
// Latency: none, declarations only.
// Backpressure: not applicable.
package noc_arb_pkg;

  localparam int ARB_RR     = 0;
  localparam int ARB_STATIC = 1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width for n competing inputs; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between the competing inputs and the channel arbiter.
// Latency: none, wiring only.
// Backpressure: en_i gates new ownership, release_i ends the current one.
// Ports: req_i/en_i/release_i driven by master; grant_oh_o/grant_idx_o/grant_vld_o driven by slave.
interface round_robin_arbiter_if
  import noc_arb_pkg::*;
#(
  parameter int IN_N  = 5,
  parameter int IDX_W = idx_w(IN_N)
);

  logic [IN_N-1:0]  req_i;
  logic             en_i;
  logic             release_i;
  logic [IN_N-1:0]  grant_oh_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             grant_vld_o;

  modport master (
    output req_i, en_i, release_i,
    input  grant_oh_o, grant_idx_o, grant_vld_o
  );

  modport slave (
    input  req_i, en_i, release_i,
    output grant_oh_o, grant_idx_o, grant_vld_o
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational picker: round-robin search upward from ptr with wrap, or highest index wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is used.
// Ports: req (requests), ptr (search start), mode (1 = static), gnt_oh/gnt_idx (winner).
module arb_pick
  import noc_arb_pkg::*;
#(
  parameter int IN_N  = 5,
  parameter int IDX_W = idx_w(IN_N)
) (
  input  logic [IN_N-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [IN_N-1:0]  gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;
  int   j;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    if (mode) begin
      // Ascending scan, last hit kept: highest requesting index wins.
      for (int i = 0; i < IN_N; i++) begin
        if (req[i]) gnt_idx = IDX_W'(i);
      end
    end else begin
      for (int k = 0; k < IN_N; k++) begin
        j = (int'(ptr) + k) % IN_N;
        if (!found && req[j]) begin
          found   = 1'b1;
          gnt_idx = IDX_W'(j);
        end
      end
    end
    gnt_oh = (|req) ? (IN_N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Output-channel arbiter: grants one input and holds it until its tail flit releases the channel.
// Latency: 1 cycle from request/enable to registered grant; back-to-back grants on release.
// Backpressure: no new owner while en_i is low; ownership is held until release_i.
// Ports: clk_i, rst_i (sync, active-high), arb (slave side of round_robin_arbiter_if).
module round_robin_arbiter
  import noc_arb_pkg::*;
#(
  parameter int IN_N     = 5,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  round_robin_arbiter_if.slave arb
);

  localparam int IDX_W = idx_w(IN_N);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IN_N-1:0]  grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

  logic [IDX_W-1:0] ptr_rel;
  logic [IDX_W-1:0] ptr_arb;
  logic             can_arb;
  logic [IN_N-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;

  // Pointer moves past the owner on release; static mode pins it at zero.
  assign ptr_rel = (ARB_MODE == ARB_STATIC)              ? '0 :
                   (grant_idx_q == IDX_W'(IN_N - 1))      ? '0 :
                   grant_idx_q + IDX_W'(1);

  // A releasing owner's successor is picked with the post-release pointer
  // in the same cycle, so the channel sees no idle bubble.
  assign ptr_arb = (state_q == ARB_LOCKED && arb.release_i) ? ptr_rel : ptr_q;
  assign can_arb = (state_q == ARB_IDLE) || arb.release_i;

  arb_pick #(
    .IN_N  (IN_N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (arb.req_i),
    .ptr     (ptr_arb),
    .mode    (ARB_MODE == ARB_STATIC),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    if (can_arb) begin
      ptr_d = ptr_arb;
      if (arb.en_i && (|arb.req_i)) begin
        state_d     = ARB_LOCKED;
        grant_oh_d  = pick_oh;
        grant_idx_d = pick_idx;
      end else begin
        // Index keeps the last owner; only the one-hot clears.
        state_d    = ARB_IDLE;
        grant_oh_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign arb.grant_oh_o  = grant_oh_q;
  assign arb.grant_idx_o = grant_idx_q;
  assign arb.grant_vld_o = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: one round-robin and one static-priority instance.
// Latency: model expects grants one edge after request/enable.
// Backpressure: en_i gating and release_i handover exercised directly.
module tb_round_robin_arbiter;
  import noc_arb_pkg::*;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  round_robin_arbiter_if #(.IN_N(N)) bus_rr ();
  round_robin_arbiter_if #(.IN_N(N)) bus_st ();

  round_robin_arbiter #(.IN_N(N), .ARB_MODE(ARB_RR)) dut_rr (
    .clk_i (clk),
    .rst_i (rst),
    .arb   (bus_rr)
  );

  round_robin_arbiter #(.IN_N(N), .ARB_MODE(ARB_STATIC)) dut_st (
    .clk_i (clk),
    .rst_i (rst),
    .arb   (bus_st)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance (0 = round-robin, 1 = static): current owner
  // (-1 when the channel is free), search pointer, last granted index.
  int m_owner[2];
  int m_ptr[2];
  int m_last[2];

  function automatic int choose(input logic [N-1:0] req, input int ptr, input bit stat);
    if (stat) begin
      for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic r, input logic [N-1:0] req,
                            input logic en, input logic rel);
    bit free_now;
    if (r) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_last[d]  = 0;
    end else begin
      free_now = (m_owner[d] < 0) || rel;
      if (m_owner[d] >= 0 && rel) m_ptr[d] = (d == 1) ? 0 : (m_owner[d] + 1) % N;
      if (free_now) m_owner[d] = (en && req != '0) ? choose(req, m_ptr[d], d == 1) : -1;
      if (m_owner[d] >= 0) m_last[d] = m_owner[d];
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model advances on every edge; DUT outputs are compared 1 time unit later.
  always @(posedge clk) begin
    model_step(0, rst, bus_rr.req_i, bus_rr.en_i, bus_rr.release_i);
    model_step(1, rst, bus_st.req_i, bus_st.en_i, bus_st.release_i);
    #1;
    cmp("rr.vld", 32'(bus_rr.grant_vld_o), 32'(m_owner[0] >= 0));
    cmp("rr.oh",  32'(bus_rr.grant_oh_o),  (m_owner[0] >= 0) ? (32'd1 << m_owner[0]) : 32'd0);
    cmp("rr.idx", 32'(bus_rr.grant_idx_o), 32'(m_last[0]));
    cmp("st.vld", 32'(bus_st.grant_vld_o), 32'(m_owner[1] >= 0));
    cmp("st.oh",  32'(bus_st.grant_oh_o),  (m_owner[1] >= 0) ? (32'd1 << m_owner[1]) : 32'd0);
    cmp("st.idx", 32'(bus_st.grant_idx_o), 32'(m_last[1]));
  end

  // Hand-computed literal expectations.
  task automatic lit_rr(input string nm, input bit v, input int idx);
    cmp({nm, ".vld"}, 32'(bus_rr.grant_vld_o), 32'(v));
    cmp({nm, ".oh"},  32'(bus_rr.grant_oh_o),  v ? (32'd1 << idx) : 32'd0);
    cmp({nm, ".idx"}, 32'(bus_rr.grant_idx_o), 32'(idx));
  endtask

  task automatic lit_st(input string nm, input bit v, input int idx);
    cmp({nm, ".vld"}, 32'(bus_st.grant_vld_o), 32'(v));
    cmp({nm, ".oh"},  32'(bus_st.grant_oh_o),  v ? (32'd1 << idx) : 32'd0);
    cmp({nm, ".idx"}, 32'(bus_st.grant_idx_o), 32'(idx));
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic e, input logic rl);
    @(negedge clk);
    rst              = r;
    bus_rr.req_i     = rq;
    bus_rr.en_i      = e;
    bus_rr.release_i = rl;
    @(posedge clk);
    #2;
  endtask

  task automatic cys(input logic [N-1:0] rq, input logic e, input logic rl);
    @(negedge clk);
    bus_st.req_i     = rq;
    bus_st.en_i      = e;
    bus_st.release_i = rl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_last[d]  = 0;
    end
    rst              = 1'b1;
    bus_rr.req_i     = 5'b11111;
    bus_rr.en_i      = 1'b1;
    bus_rr.release_i = 1'b0;
    bus_st.req_i     = '0;
    bus_st.en_i      = 1'b0;
    bus_st.release_i = 1'b0;

    // Reset held two cycles with every input requesting.
    cyc(1'b1, 5'b11111, 1'b1, 1'b0); lit_rr("rst0", 1'b0, 0);
    cyc(1'b1, 5'b11111, 1'b1, 1'b0); lit_rr("rst1", 1'b0, 0);
    cyc(1'b0, 5'b11111, 1'b1, 1'b0); lit_rr("first", 1'b1, 0);

    // Rotation with no bubble: 1,2,3,4,0.
    cyc(1'b0, 5'b11111, 1'b1, 1'b1); lit_rr("rot1", 1'b1, 1);
    cyc(1'b0, 5'b11111, 1'b1, 1'b1); lit_rr("rot2", 1'b1, 2);
    cyc(1'b0, 5'b11111, 1'b1, 1'b1); lit_rr("rot3", 1'b1, 3);
    cyc(1'b0, 5'b11111, 1'b1, 1'b1); lit_rr("rot4", 1'b1, 4);
    cyc(1'b0, 5'b11111, 1'b1, 1'b1); lit_rr("rot0", 1'b1, 0);

    // Grant to 2, then hold through owner deassertion and en_i toggling.
    cyc(1'b0, 5'b00100, 1'b1, 1'b1); lit_rr("get2", 1'b1, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 5'b11011, logic'(i % 2), 1'b0);
      lit_rr("hold", 1'b1, 2);
    end

    // Release with en_i low: channel goes free, pointer now 3.
    cyc(1'b0, 5'b11011, 1'b0, 1'b1); lit_rr("rel_idle", 1'b0, 2);

    // en_i gating.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'b00100, 1'b0, 1'b0);
      lit_rr("en_low", 1'b0, 2);
    end
    cyc(1'b0, 5'b00100, 1'b1, 1'b0); lit_rr("en_rise", 1'b1, 2);

    // Wrap: owner 3 released (pointer 4), requests 0 and 1.
    cyc(1'b0, 5'b01000, 1'b1, 1'b1); lit_rr("get3", 1'b1, 3);
    cyc(1'b0, 5'b00011, 1'b1, 1'b1); lit_rr("wrap0", 1'b1, 0);
    cyc(1'b0, 5'b00011, 1'b1, 1'b1); lit_rr("wrap1", 1'b1, 1);
    cyc(1'b0, 5'b00000, 1'b1, 1'b1); lit_rr("drain", 1'b0, 1);

    // Release while free must not move the pointer (still 2).
    cyc(1'b0, 5'b00000, 1'b1, 1'b1); lit_rr("idle_rel", 1'b0, 1);
    cyc(1'b0, 5'b11111, 1'b1, 1'b1); lit_rr("ptr_kept", 1'b1, 2);

    // Reset while owned aborts, then arbitration restarts from 0.
    cyc(1'b1, 5'b11111, 1'b1, 1'b0); lit_rr("rst_lock", 1'b0, 0);
    cyc(1'b0, 5'b11111, 1'b1, 1'b0); lit_rr("post_rst", 1'b1, 0);
    cyc(1'b0, 5'b00000, 1'b0, 1'b1); lit_rr("rr_off", 1'b0, 0);

    // Static priority: highest index wins across releases.
    cys(5'b10110, 1'b1, 1'b0); lit_st("st_first", 1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      cys(5'b10110, 1'b1, 1'b1);
      lit_st("st_again", 1'b1, 4);
    end
    cys(5'b00110, 1'b1, 1'b1); lit_st("st_next2", 1'b1, 2);
    cys(5'b00110, 1'b1, 1'b1); lit_st("st_keep2", 1'b1, 2);
    cys(5'b10110, 1'b0, 1'b1); lit_st("st_idle", 1'b0, 2);
    cys(5'b10110, 1'b1, 1'b0); lit_st("st_back4", 1'b1, 4);

    // Mixed traffic on both instances, checked by the model only.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus_rr.req_i     = N'($urandom_range(0, 31));
      bus_rr.en_i      = ($urandom_range(0, 3) != 0);
      bus_rr.release_i = logic'($urandom_range(0, 1));
      bus_st.req_i     = N'($urandom_range(0, 31));
      bus_st.en_i      = ($urandom_range(0, 3) != 0);
      bus_st.release_i = logic'($urandom_range(0, 1));
    end
    @(posedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
